fetch_align_buffer: RTL and testbench
=====================================

FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 Parameter FETCH_W, 32, fetch word width in bits; legal values are 32 and 64.
REQ-002 Parameter DEPTH_HW, 8, halfword buffer depth; power of 2, >= 2*(FETCH_W/16).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 flush  in  1  redirect request (jump/branch taken).
REQ-006 flush_pc  in  32  redirect target; bit 0 ignored; bit 1 may be set.
REQ-007 fetch_valid  in  1  imem word present.
REQ-008 fetch_ready  out  1  buffer can accept one full fetch word.
REQ-009 fetch_data  in  FETCH_W  imem word; halfword 0 = lowest address.
REQ-010 ins_valid  out  1  complete instruction available.
REQ-011 ins_ready  in  1  decode accepts instruction.
REQ-012 ins_ir  out  32  instruction; compressed: {16'h0000, hw0}; full: {hw1, hw0}.
REQ-013 ins_pc  out  32  true byte address of ins_ir.
REQ-014 ins_compressed  out  1  ins_ir holds a 16-bit instruction.
REQ-015 retired_count  out  32  number of accepted instructions.

Function
REQ-016 Buffer: circular halfword queue with rd_ptr, wr_ptr and count (0..DEPTH_HW); pointers wrap modulo DEPTH_HW.
REQ-017 Push when fetch_valid & fetch_ready & ~flush; appends FETCH_W/16 halfwords in address order (fewer in DROP, REQ-024).
REQ-018 fetch_ready = 1 iff (DEPTH_HW - count) >= FETCH_W/16, using registered count; same-cycle pop is not credited.
REQ-019 hw0 = queue[rd_ptr]; hw1 = queue[rd_ptr+1].
REQ-020 ins_valid = count>=1 & hw0[1:0]!=2'b11 (compressed), or count>=2 & hw0[1:0]==2'b11 (full); combinational from registered state.
REQ-021 count==1 with hw0[1:0]==2'b11: ins_valid=0 until the next push; no partial output.
REQ-022 Pop on ins_valid & ins_ready & ~flush: remove 1 halfword (compressed) or 2 (full); ins_pc advances by 2 or 4.
REQ-023 Push and pop in the same cycle: count_next = count + pushed - popped; both pointers advance.
REQ-024 States RUN and DROP. flush (any state) -> DROP: count=0, pointers reset, ins_pc=flush_pc with bit 0 cleared, in-flight fetch word discarded, pop suppressed. DROP on push -> RUN; only halfwords at index >= flush_pc[log2(FETCH_W/8)-1:1] are appended.
REQ-025 In DROP, ins_valid=0.
REQ-026 flush has priority over push and pop in the same cycle.
REQ-027 retired_count increments by 1 per pop and wraps from 32'hFFFFFFFF to 0; flush does not clear it.
REQ-028 Word is not overwritten: a push is never accepted when fetch_ready=0, whatever fetch_valid is.

Reset
REQ-029 On rst_n low: state=DROP, count=0, pointers=0, ins_pc=32'h00000060, retired_count=0, fetch_ready=1, ins_valid=0, ins_compressed=0, ins_ir=32'h0.
REQ-030 Reset mid-operation discards all buffered halfwords; the first push after release is treated as the first fetch after a flush to 32'h60.
REQ-031 Buffer storage array is not reset; only control state is.

Structure
REQ-032 align_state_t enum (RUN, DROP) and reset PC constant live in rv32i_types.
REQ-033 Halfword storage plus pointer/count logic is one sub-module, halfword_queue, parametrised by DEPTH_HW and push width.
REQ-034 Alignment, PC tracking and counter logic live in fetch_align_buffer.

Verification
REQ-035 FETCH_W=32: push 32'h00130093 after reset -> ins_ir=32'h00130093, ins_pc=32'h60, compressed=0, count returns to 0.
REQ-036 Push 32'h45014501 -> two compressed instructions at pc 32'h60 and 32'h62, ins_ir=32'h00004501 each.
REQ-037 Straddle: push 32'h00934501 then 32'h45010013 -> compressed at 60, full 32'h00130093 at 62, compressed at 66.
REQ-038 flush_pc=32'h102 with push 32'hAAAAAAAA same cycle -> push discarded; next push 32'h00934501 -> only hw1 kept; count=1, ins_valid=0 until next push.
REQ-039 FETCH_W=64, DEPTH_HW=8, ins_ready=0: two pushes -> fetch_ready=0 at count=8; third fetch_valid not accepted; no overwrite.
REQ-040 rst_n pulsed low while count=3 -> outputs reach REQ-029 values asynchronously; retired_count=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the instruction fetch alignment path.
package rv32i_types;

   typedef enum logic {
      RUN  = 1'b0,
      DROP = 1'b1
   } align_state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_0060;

   function automatic logic [31:0] halfword_pc(input logic [31:0] pc);
      return pc & ~32'h1;
   endfunction

endpackage

// File: rtl/halfword_queue.sv
// Circular halfword queue: writes a fetch word (minus leading skipped halfwords),
// pops one or two halfwords, and exposes the two oldest entries.
module halfword_queue #(
   parameter int DEPTH_HW = 8,
   parameter int PUSH_HW  = 2,
   localparam int PTR_W   = $clog2(DEPTH_HW),
   localparam int CNT_W   = $clog2(DEPTH_HW + 1),
   localparam int SKIP_W  = $clog2(PUSH_HW)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clr,
   input  logic                   i_push,
   input  logic [SKIP_W-1:0]      i_push_skip,
   input  logic [PUSH_HW*16-1:0]  i_push_data,
   input  logic                   i_pop,
   input  logic                   i_pop_two,
   output logic [15:0]            o_hw0,
   output logic [15:0]            o_hw1,
   output logic [CNT_W-1:0]       o_count
);

   logic [15:0]      r_mem [DEPTH_HW];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_push_n;
   logic [CNT_W-1:0] w_pop_n;

   always_comb begin
      w_push_n = '0;
      w_pop_n  = '0;
      if (i_push)
         w_push_n = CNT_W'(PUSH_HW) - CNT_W'(i_push_skip);
      if (i_pop)
         w_pop_n = i_pop_two ? CNT_W'(2) : CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
         r_count  <= r_count + w_push_n - w_pop_n;
      end
   end

   // Storage holds data only; validity is tracked entirely by r_count.
   always_ff @(posedge clk) begin
      if (i_push && !i_clr) begin
         for (int i = 0; i < PUSH_HW; i++) begin
            if (i >= int'(i_push_skip))
               r_mem[r_wr_ptr + PTR_W'(i - int'(i_push_skip))] <= i_push_data[16*i +: 16];
         end
      end
   end

   assign o_hw0   = r_mem[r_rd_ptr];
   assign o_hw1   = r_mem[r_rd_ptr + PTR_W'(1)];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_align_buffer.sv
// Splits imem fetch words into 16/32-bit instructions with their byte PCs.
// state | meaning
// RUN   | queue holds halfwords from the current fetch stream
// DROP  | after flush/reset: queue empty, next push is trimmed to the target PC
module fetch_align_buffer
   import rv32i_types::*;
#(
   parameter int FETCH_W  = 32,
   parameter int DEPTH_HW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [31:0]        flush_pc,
   input  logic               fetch_valid,
   output logic               fetch_ready,
   input  logic [FETCH_W-1:0] fetch_data,
   output logic               ins_valid,
   input  logic               ins_ready,
   output logic [31:0]        ins_ir,
   output logic [31:0]        ins_pc,
   output logic               ins_compressed,
   output logic [31:0]        retired_count
);

   localparam int PUSH_HW = FETCH_W / 16;
   localparam int SKIP_W  = $clog2(PUSH_HW);
   localparam int CNT_W   = $clog2(DEPTH_HW + 1);

   align_state_t      r_state;
   align_state_t      w_state_next;
   logic [31:0]       r_ins_pc;
   logic [31:0]       r_retired;
   logic [15:0]       w_hw0;
   logic [15:0]       w_hw1;
   logic [CNT_W-1:0]  w_count;
   logic [SKIP_W-1:0] w_skip;
   logic              w_push;
   logic              w_pop;
   logic              w_full_ins;

   halfword_queue #(
      .DEPTH_HW (DEPTH_HW),
      .PUSH_HW  (PUSH_HW)
   ) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (flush),
      .i_push      (w_push),
      .i_push_skip (w_skip),
      .i_push_data (fetch_data),
      .i_pop       (w_pop),
      .i_pop_two   (w_full_ins),
      .o_hw0       (w_hw0),
      .o_hw1       (w_hw1),
      .o_count     (w_count)
   );

   // While in DROP ins_pc still holds the redirect target, so its low bits
   // select where in the first fetch word the stream actually begins.
   assign w_skip      = (r_state == DROP) ? r_ins_pc[SKIP_W:1] : '0;
   assign fetch_ready = (CNT_W'(DEPTH_HW) - w_count) >= CNT_W'(PUSH_HW);
   assign w_push      = fetch_valid & fetch_ready & ~flush;
   assign w_full_ins  = (w_hw0[1:0] == 2'b11);

   always_comb begin
      ins_valid = 1'b0;
      if (r_state == RUN)
         ins_valid = w_full_ins ? (w_count >= CNT_W'(2)) : (w_count != '0);
   end

   assign w_pop          = ins_valid & ins_ready & ~flush;
   assign ins_compressed = ins_valid & ~w_full_ins;
   assign ins_ir         = !ins_valid ? 32'h0 :
                           w_full_ins ? {w_hw1, w_hw0} : {16'h0000, w_hw0};
   assign ins_pc         = r_ins_pc;
   assign retired_count  = r_retired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= DROP;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (flush)
         w_state_next = DROP;
      else if (r_state == DROP && w_push)
         w_state_next = RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ins_pc  <= RESET_PC;
         r_retired <= '0;
      end else begin
         if (flush)
            r_ins_pc <= halfword_pc(flush_pc);
         else if (w_pop)
            r_ins_pc <= r_ins_pc + (w_full_ins ? 32'd4 : 32'd2);
         if (w_pop)
            r_retired <= r_retired + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench: 32-bit fetch vector table, 64-bit fill/no-overwrite and async reset sequences.
module tb_fetch_align_buffer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        s_flush, s_fv, s_fr, s_iv, s_rdy, s_c;
   logic [31:0] s_fpc, s_fd, s_ir, s_pc, s_ret;

   logic        d_flush, d_fv, d_fr, d_iv, d_rdy, d_c;
   logic [31:0] d_fpc, d_ir, d_pc, d_ret;
   logic [63:0] d_fd;

   fetch_align_buffer #(.FETCH_W(32), .DEPTH_HW(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(s_flush), .flush_pc(s_fpc),
      .fetch_valid(s_fv), .fetch_ready(s_fr), .fetch_data(s_fd),
      .ins_valid(s_iv), .ins_ready(s_rdy), .ins_ir(s_ir), .ins_pc(s_pc),
      .ins_compressed(s_c), .retired_count(s_ret)
   );

   fetch_align_buffer #(.FETCH_W(64), .DEPTH_HW(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(d_flush), .flush_pc(d_fpc),
      .fetch_valid(d_fv), .fetch_ready(d_fr), .fetch_data(d_fd),
      .ins_valid(d_iv), .ins_ready(d_rdy), .ins_ir(d_ir), .ins_pc(d_pc),
      .ins_compressed(d_c), .retired_count(d_ret)
   );

   typedef struct {
      logic        fl;
      logic [31:0] fpc;
      logic        fv;
      logic [31:0] fd;
      logic        rdy;
      logic        e_fr;
      logic        e_iv;
      logic [31:0] e_ir;
      logic [31:0] e_pc;
      logic        e_c;
      logic [31:0] e_ret;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vecs[NVEC];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic fv,
                               input logic [31:0] fd, input logic rdy, input logic e_fr,
                               input logic e_iv, input logic [31:0] e_ir,
                               input logic [31:0] e_pc, input logic e_c,
                               input logic [31:0] e_ret);
      vec_t v;
      v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.rdy = rdy;
      v.e_fr = e_fr; v.e_iv = e_iv; v.e_ir = e_ir; v.e_pc = e_pc;
      v.e_c = e_c; v.e_ret = e_ret;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // fl fpc fv fd rdy | fr iv ir pc c ret
      vecs[0]  = mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h60,  0, 0);
      vecs[1]  = mk(0, 0, 1, 32'h00130093, 0, 1, 0, 32'h0,        32'h60,  0, 0);
      vecs[2]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00130093, 32'h60,  0, 0);
      vecs[3]  = mk(0, 0, 1, 32'h45014501, 0, 1, 0, 32'h0,        32'h64,  0, 1);
      vecs[4]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00004501, 32'h64,  1, 1);
      vecs[5]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00004501, 32'h66,  1, 2);
      vecs[6]  = mk(0, 0, 1, 32'h00934501, 0, 1, 0, 32'h0,        32'h68,  0, 3);
      vecs[7]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00004501, 32'h68,  1, 3);
      vecs[8]  = mk(0, 0, 1, 32'h45010013, 1, 1, 0, 32'h0,        32'h6A,  0, 4);
      vecs[9]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00130093, 32'h6A,  0, 4);
      vecs[10] = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00004501, 32'h6E,  1, 5);
      vecs[11] = mk(0, 0, 1, 32'h45014501, 0, 1, 0, 32'h0,        32'h70,  0, 6);
      vecs[12] = mk(0, 0, 1, 32'h00130093, 1, 1, 1, 32'h00004501, 32'h70,  1, 6);
      vecs[13] = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00004501, 32'h72,  1, 7);
      vecs[14] = mk(1, 32'h102, 1, 32'hAAAAAAAA, 1, 1, 1, 32'h00130093, 32'h74, 0, 8);
      vecs[15] = mk(0, 0, 1, 32'h00934501, 1, 1, 0, 32'h0,        32'h102, 0, 8);
      vecs[16] = mk(0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h102, 0, 8);
      vecs[17] = mk(0, 0, 1, 32'h45010013, 0, 1, 0, 32'h0,        32'h102, 0, 8);
      vecs[18] = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00130093, 32'h102, 0, 8);
      vecs[19] = mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h00004501, 32'h106, 1, 9);
      vecs[20] = mk(1, 32'h201, 0, 32'h0,  0, 1, 0, 32'h0,        32'h108, 0, 10);
      vecs[21] = mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h200, 0, 10);

      s_flush = 0; s_fpc = 0; s_fv = 0; s_fd = 0; s_rdy = 0;
      d_flush = 0; d_fpc = 0; d_fv = 0; d_fd = 0; d_rdy = 0;
      rst_n = 1'b0;
      #12;
      check("rst_fetch_ready", 0, 32'(s_fr), 32'd1);
      check("rst_ins_valid",   0, 32'(s_iv), 32'd0);
      check("rst_ins_ir",      0, s_ir, 32'h0);
      check("rst_ins_pc",      0, s_pc, 32'h60);
      check("rst_compressed",  0, 32'(s_c), 32'd0);
      check("rst_retired",     0, s_ret, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         s_flush = vecs[i].fl; s_fpc = vecs[i].fpc; s_fv = vecs[i].fv;
         s_fd = vecs[i].fd; s_rdy = vecs[i].rdy;
         #1;
         check("v_fetch_ready", i, 32'(s_fr), 32'(vecs[i].e_fr));
         check("v_ins_valid",   i, 32'(s_iv), 32'(vecs[i].e_iv));
         check("v_ins_pc",      i, s_pc, vecs[i].e_pc);
         check("v_retired",     i, s_ret, vecs[i].e_ret);
         if (vecs[i].e_iv) begin
            check("v_ins_ir",   i, s_ir, vecs[i].e_ir);
            check("v_compr",    i, 32'(s_c), 32'(vecs[i].e_c));
         end
      end
      @(negedge clk);
      s_flush = 0; s_fv = 0; s_rdy = 0;

      // 64-bit fetch: fill to 8 halfwords with decode stalled, then try to overwrite.
      d_fv = 1; d_fd = 64'h0013009300130093; d_rdy = 0;
      #1 check("w64_ready_empty", 0, 32'(d_fr), 32'd1);
      @(negedge clk);
      #1 check("w64_ready_half", 0, 32'(d_fr), 32'd1);
      check("w64_valid_half", 0, 32'(d_iv), 32'd1);
      @(negedge clk);
      d_fd = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
         #1 check("w64_ready_full", k, 32'(d_fr), 32'd0);
         @(negedge clk);
      end
      d_fv = 0; d_rdy = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("w64_drain_valid", k, 32'(d_iv), 32'd1);
         check("w64_drain_ir",    k, d_ir, 32'h00130093);
         check("w64_drain_pc",    k, d_pc, 32'h60 + 32'(4 * k));
         @(negedge clk);
      end
      #1;
      check("w64_empty_valid", 0, 32'(d_iv), 32'd0);
      check("w64_retired",     0, d_ret, 32'd4);
      check("w64_ready_again", 0, 32'(d_fr), 32'd1);
      d_rdy = 0;

      // Build count=3 on the 32-bit instance, then pulse reset between edges.
      @(negedge clk);
      s_fv = 1; s_fd = 32'h45014501;
      @(negedge clk);
      s_fd = 32'h00130093;
      @(negedge clk);
      s_fv = 0; s_rdy = 1;
      @(negedge clk);
      s_rdy = 0;
      #1;
      check("pre_rst_valid",   0, 32'(s_iv), 32'd1);
      check("pre_rst_pc",      0, s_pc, 32'h202);
      check("pre_rst_retired", 0, s_ret, 32'd11);
      #1 rst_n = 1'b0;
      #1;
      check("arst_fetch_ready", 0, 32'(s_fr), 32'd1);
      check("arst_ins_valid",   0, 32'(s_iv), 32'd0);
      check("arst_ins_ir",      0, s_ir, 32'h0);
      check("arst_ins_pc",      0, s_pc, 32'h60);
      check("arst_compressed",  0, 32'(s_c), 32'd0);
      check("arst_retired",     0, s_ret, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      s_fv = 1; s_fd = 32'h00130093;
      @(negedge clk);
      s_fv = 0;
      #1;
      check("post_rst_valid", 0, 32'(s_iv), 32'd1);
      check("post_rst_ir",    0, s_ir, 32'h00130093);
      check("post_rst_pc",    0, s_pc, 32'h60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
